// File: rtl/history_drain.sv
// history_drain: reader side of the 16-bank history RAM. Streams committed bytes out as
// 512-bit beats in address order and reports consumed space through the drained pointer.
module history_drain #(
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned BUF_BEATS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    total_len,
  input  logic [31:0]    committed,
  output logic           rd_en,
  output logic [8:0]     rd_addr,
  input  logic [1023:0]  rd_data,
  output logic [511:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [6:0]     out_bytes,
  output logic [31:0]    drained,
  output logic           busy,
  output logic           done
);

  localparam int unsigned PW = (BUF_BEATS > 1) ? $clog2(BUF_BEATS) : 1;
  localparam int unsigned CW = $clog2(BUF_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     len_q, rd_ptr_q, drained_q;
  logic [511:0]    mem_q [BUF_BEATS];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   cnt_q;
  logic [RAM_LAT-1:0] vld_q;
  logic [31:0]     off_q [RAM_LAT];

  logic            issue, pop, push_lo, ret_vld;
  logic [31:0]     ret_off, need_slots, need_commit, remaining;
  logic [32:0]     row_end;
  logic [1:0]      push_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == BUF_BEATS - 1) ? '0 : p + PW'(1);
  endfunction

  // Read issue: row must be committed (or be the tail) and the buffer must have room for
  // both beats of this row on top of everything already in flight.
  always_comb begin
    row_end     = {1'b0, rd_ptr_q} + 33'd128;
    need_commit = (row_end > {1'b0, len_q}) ? len_q : row_end[31:0];
    need_slots  = 32'(cnt_q) + 32'd2;
    for (int i = 0; i < RAM_LAT; i++) begin
      if (vld_q[i]) need_slots = need_slots + 32'd2;
    end
    issue = (state_q == StRun) && (rd_ptr_q < len_q) && (committed >= need_commit) &&
            (need_slots <= 32'(BUF_BEATS));
  end

  // Returned row splits into upper and lower beats; the lower beat is dropped past the end.
  always_comb begin
    ret_vld   = vld_q[RAM_LAT-1];
    ret_off   = off_q[RAM_LAT-1];
    push_lo   = ret_vld && (({1'b0, ret_off} + 33'd64) < {1'b0, len_q});
    push_n    = {1'b0, ret_vld} + {1'b0, push_lo};
    out_valid = (cnt_q != '0);
    pop       = out_valid && out_ready;
    // drained equals the offset of the beat at the head of the buffer
    remaining = len_q - drained_q;
    out_data  = out_valid ? mem_q[head_q] : '0;
    out_bytes = !out_valid ? 7'd0 : ((remaining >= 32'd64) ? 7'd64 : remaining[6:0]);
    out_last  = out_valid && (remaining <= 32'd64);
    rd_en     = issue;
    rd_addr   = rd_ptr_q[15:7];
    drained   = drained_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  // Job sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = (total_len == 32'd0) ? StDone : StRun;
      StRun:  if (pop && out_last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Job length, read pointer and drained pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      rd_ptr_q  <= '0;
      drained_q <= '0;
    end else if (state_q == StIdle && start) begin
      len_q     <= total_len;
      rd_ptr_q  <= '0;
      drained_q <= '0;
    end else begin
      if (issue) rd_ptr_q  <= rd_ptr_q + 32'd128;
      if (pop)   drained_q <= drained_q + 32'(out_bytes);
    end
  end

  // Read latency pipeline; reset discards anything still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) off_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      off_q[0] <= rd_ptr_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        off_q[i] <= off_q[i-1];
      end
    end
  end

  // Buffer pointers and occupancy; up to two pushes and one pop per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (ret_vld) tail_q <= push_lo ? ptr_inc(ptr_inc(tail_q)) : ptr_inc(tail_q);
      if (pop)     head_q <= ptr_inc(head_q);
      cnt_q <= cnt_q + CW'(push_n) - CW'(pop);
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (ret_vld) begin
      mem_q[tail_q] <= rd_data[1023:512];
      if (push_lo) mem_q[ptr_inc(tail_q)] <= rd_data[511:0];
    end
  end

endmodule

// File: tb/tb_history_drain.sv
// Self-checking bench for history_drain: byte-level stream model plus directed jobs.
module tb_history_drain;

  localparam int unsigned BUF_BEATS = 4;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [31:0]   total_len, committed;
  logic          rd_en, out_valid, out_last, busy, done;
  logic [8:0]    rd_addr;
  logic [1023:0] rd_data;
  logic [511:0]  out_data;
  logic [6:0]    out_bytes;
  logic [31:0]   drained;

  logic [7:0]    ram [65536];

  int unsigned pass_cnt = 0, total_cnt = 0;
  // model state
  int unsigned m_len, m_beat, m_drained, m_row, m_issued, m_acc;
  bit          m_busy, m_done_next;
  // per-job statistics
  int unsigned beats_seen, rd_cnt, done_cnt, first_bytes, last_bytes;

  history_drain #(.RAM_LAT(1), .BUF_BEATS(BUF_BEATS)) dut (
    .clk(clk), .rst(rst), .start(start), .total_len(total_len), .committed(committed),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_bytes(out_bytes), .drained(drained), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hbyte(input int unsigned a);
    return 8'((a * 37) ^ ((a >> 7) * 5) ^ (a >> 13));
  endfunction

  function automatic logic [511:0] exp_beat(input int unsigned b);
    logic [511:0] r;
    for (int j = 0; j < 64; j++) r[511-8*j -: 8] = ram[(b * 64 + j) & 32'hFFFF];
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bank array: one cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int j = 0; j < 128; j++) rd_data[1023-8*j -: 8] <= ram[{rd_addr, 7'(j)}];
    end
  end

  // Compare process: checks every cycle against the stream model.
  always @(negedge clk) begin
    bit          this_done;
    int unsigned rem, nb;
    if (rst) begin
      m_busy = 0; m_done_next = 0; m_len = 0; m_beat = 0; m_drained = 0;
      m_row = 0; m_issued = 0; m_acc = 0;
    end else begin
      this_done   = m_done_next;
      m_done_next = 0;
      rem = m_len - m_beat * 64;
      chk("done", 512'(done), 512'(this_done));
      chk("busy", 512'(busy), 512'(m_busy));
      chk("drained", 512'(drained), 512'(m_drained));
      if (out_valid) begin
        chk("beat_expected", 512'(m_busy && (m_beat * 64 < m_len)), 512'(1));
        chk("out_data", out_data, exp_beat(m_beat));
        chk("out_bytes", 512'(out_bytes), 512'((rem >= 64) ? 64 : rem));
        chk("out_last", 512'(out_last), 512'(rem <= 64));
      end else begin
        chk("idle_out", 512'({out_last, out_bytes}), 512'(0));
      end
      if (rd_en) begin
        nb = (m_row * 128 + 64 < m_len) ? 2 : 1;
        chk("rd_addr", 512'(rd_addr), 512'(m_row[8:0]));
        chk("rd_in_range", 512'(m_row * 128 < m_len), 512'(1));
        chk("rd_committed",
            512'(committed >= ((m_row * 128 + 128 < m_len) ? m_row * 128 + 128 : m_len)),
            512'(1));
        chk("occupancy", 512'(m_issued + nb - m_acc <= BUF_BEATS), 512'(1));
        m_issued += nb;
        m_row++;
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        if (beats_seen == 0) first_bytes = out_bytes;
        last_bytes = out_bytes;
        beats_seen++;
        m_drained += (rem >= 64) ? 64 : rem;
        m_beat++;
        m_acc++;
        if (m_beat * 64 >= m_len) m_done_next = 1;
      end
      if (done) done_cnt++;
      if (start && !m_busy) begin
        m_busy = 1; m_len = total_len; m_beat = 0; m_drained = 0;
        m_row = 0; m_issued = 0; m_acc = 0;
        if (total_len == 0) m_done_next = 1;
      end
      if (this_done) m_busy = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] len);
    beats_seen = 0; rd_cnt = 0; done_cnt = 0; first_bytes = 0; last_bytes = 0;
    @(posedge clk); #1;
    start = 1'b1; total_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: one cycle on, three off
  task automatic wait_done(input int timeout, input int mode);
    int c = 0;
    while (done_cnt == 0 && c < timeout) begin
      @(posedge clk); #1;
      if (mode == 1) out_ready = (c % 4 == 0);
      c++;
    end
    chk("job_timeout", 512'(done_cnt != 0), 512'(1));
    out_ready = 1'b1;
  endtask

  initial begin
    int c;
    for (int a = 0; a < 65536; a++) ram[a] = hbyte(a);
    rd_data = '0; rst = 1'b1; start = 1'b0; total_len = '0; committed = '0; out_ready = 1'b0;
    cyc(3);
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_rd_en", 512'(rd_en), 512'(0));
    chk("rst_drained", 512'(drained), 512'(0));
    chk("rst_busy_done", 512'({busy, done}), 512'(0));
    chk("rst_out", {out_data[511:7], out_bytes}, 512'(0));
    rst = 1'b0;
    cyc(2);

    // full rows, ready held high
    committed = 32'd256; out_ready = 1'b1;
    do_start(32'd256);
    wait_done(200, 0);
    chk("t1_beats", 512'(beats_seen), 512'(4));
    chk("t1_reads", 512'(rd_cnt), 512'(2));
    chk("t1_last_bytes", 512'(last_bytes), 512'(64));
    chk("t1_drained", 512'(drained), 512'(256));
    cyc(4);
    chk("t1_done_once", 512'(done_cnt), 512'(1));

    // commit gating on a short tail row
    committed = 32'd0;
    do_start(32'd100);
    cyc(6);
    chk("t2_no_read_0", 512'(rd_cnt), 512'(0));
    committed = 32'd99;
    cyc(6);
    chk("t2_no_read_99", 512'(rd_cnt), 512'(0));
    committed = 32'd100;
    wait_done(100, 0);
    chk("t2_beats", 512'(beats_seen), 512'(2));
    chk("t2_first_bytes", 512'(first_bytes), 512'(64));
    chk("t2_last_bytes", 512'(last_bytes), 512'(36));
    chk("t2_drained", 512'(drained), 512'(100));

    // empty job
    do_start(32'd0);
    wait_done(10, 0);
    chk("t3_reads", 512'(rd_cnt), 512'(0));
    chk("t3_beats", 512'(beats_seen), 512'(0));
    chk("t3_done", 512'(done_cnt), 512'(1));
    cyc(2);

    // throttled downstream
    committed = 32'd1024;
    do_start(32'd1024);
    wait_done(2000, 1);
    chk("t4_beats", 512'(beats_seen), 512'(16));
    chk("t4_drained", 512'(drained), 512'(1024));

    // 128 KB job wraps the row index twice
    committed = 32'd131072;
    do_start(32'd131072);
    wait_done(10000, 0);
    chk("t5_beats", 512'(beats_seen), 512'(2048));
    chk("t5_reads", 512'(rd_cnt), 512'(1024));
    chk("t5_drained", 512'(drained), 512'(131072));

    // reset mid-job, then a clean job
    committed = 32'd1024;
    do_start(32'd1024);
    c = 0;
    while (beats_seen < 3 && c < 100) begin
      cyc(1);
      c++;
    end
    chk("t6_reached_3", 512'(beats_seen >= 3), 512'(1));
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_valid", 512'(out_valid), 512'(0));
    chk("t6_rst_drained", 512'(drained), 512'(0));
    chk("t6_rst_busy_done", 512'({busy, done, rd_en}), 512'(0));
    rst = 1'b0;
    done_cnt = 0;
    cyc(5);
    chk("t6_no_done", 512'(done_cnt), 512'(0));
    committed = 32'd256;
    do_start(32'd256);
    wait_done(200, 0);
    chk("t6_beats", 512'(beats_seen), 512'(4));
    chk("t6_reads", 512'(rd_cnt), 512'(2));
    chk("t6_drained", 512'(drained), 512'(256));
    cyc(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
